thresh_cfg_loader: RTL and testbench

- Upstream configuration stage for the eee_imgproc threshold conduits.
- Parses framed command packets from a byte stream (the UART RX byte path) into shadow registers.
- Commits the shadow registers to the active threshold outputs atomically at the next start-of-frame, so the image processor never sees a half-updated threshold set mid-frame.

---
 rtl/thresh_cfg_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_thresh_cfg_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/thresh_cfg_loader.sv
// Threshold configuration loader: parses framed command packets from the UART RX
// byte stream into shadow registers and commits them to the active threshold
// outputs atomically on the next start-of-frame.
module thresh_cfg_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter logic [7:0]  DEFAULT_SAT    = 8'd100,
  parameter logic [7:0]  DEFAULT_VAL    = 8'd100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         sof,
  output logic [143:0] threshue,
  output logic [7:0]   threshsat,
  output logic [7:0]   threshval,
  output logic [3:0]   thresholdsig,
  output logic         mode_1_new_signal,
  output logic         commit_pending,
  output logic         pkt_ok,
  output logic         pkt_err,
  output logic         committed
);

  localparam logic [7:0]  SyncByte = 8'hA5;
  localparam logic [7:0]  CmdHue   = 8'h01;
  localparam logic [7:0]  CmdSv    = 8'h02;
  localparam logic [7:0]  CmdSig   = 8'h03;
  localparam logic [7:0]  CmdCommit = 8'h10;
  localparam int unsigned TimerW   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StCmd, StPayload, StCsum} state_e;

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [4:0]          len_q, len_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [7:0]          csum_q, csum_d;
  logic [143:0]        stage_q, stage_d;
  logic [TimerW-1:0]   timer_q, timer_d;

  logic [143:0]        sh_hue_q, sh_hue_d;
  logic [7:0]          sh_sat_q, sh_sat_d;
  logic [7:0]          sh_val_q, sh_val_d;
  logic [3:0]          sh_sig_q, sh_sig_d;
  logic                sh_mode_q, sh_mode_d;

  logic [143:0]        act_hue_q, act_hue_d;
  logic [7:0]          act_sat_q, act_sat_d;
  logic [7:0]          act_val_q, act_val_d;
  logic [3:0]          act_sig_q, act_sig_d;
  logic                act_mode_q, act_mode_d;

  logic                pending_q, pending_d;
  logic                pkt_ok_q, pkt_ok_d;
  logic                pkt_err_q, pkt_err_d;
  logic                committed_q, committed_d;

  logic                timeout;
  logic                commit_acc;

  // Timeout detect: TIMEOUT_CYCLES consecutive byte-less cycles while inside a packet.
  always_comb begin
    timeout = (state_q != StIdle) && !in_valid &&
              (timer_q == TimerW'(TIMEOUT_CYCLES - 1));
  end

  // Packet parser, shadow update and frame-synchronous commit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    cmd_d       = cmd_q;
    csum_d      = csum_q;
    stage_d     = stage_q;
    sh_hue_d    = sh_hue_q;
    sh_sat_d    = sh_sat_q;
    sh_val_d    = sh_val_q;
    sh_sig_d    = sh_sig_q;
    sh_mode_d   = sh_mode_q;
    act_hue_d   = act_hue_q;
    act_sat_d   = act_sat_q;
    act_val_d   = act_val_q;
    act_sig_d   = act_sig_q;
    act_mode_d  = act_mode_q;
    pending_d   = pending_q;
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    committed_d = 1'b0;
    commit_acc  = 1'b0;

    if (in_valid || (state_q == StIdle)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    if (timeout) begin
      state_d   = StIdle;
      pkt_err_d = 1'b1;
      stage_d   = '0;
      timer_d   = '0;
    end else if (in_valid) begin
      unique case (state_q)
        StIdle: begin
          if (in_data == SyncByte) state_d = StCmd;
        end
        StCmd: begin
          cmd_d   = in_data;
          csum_d  = in_data;
          cnt_d   = '0;
          stage_d = '0;
          state_d = StPayload;
          case (in_data)
            CmdHue:    len_d = 5'd18;
            CmdSv:     len_d = 5'd2;
            CmdSig:    len_d = 5'd1;
            CmdCommit: begin
              len_d   = 5'd0;
              state_d = StCsum;
            end
            default: begin
              len_d     = 5'd0;
              state_d   = StIdle;
              pkt_err_d = 1'b1;
            end
          endcase
        end
        StPayload: begin
          stage_d[{cnt_q, 3'b000} +: 8] = in_data;
          csum_d = csum_q ^ in_data;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == len_q - 5'd1) state_d = StCsum;
        end
        StCsum: begin
          state_d = StIdle;
          if (in_data == csum_q) begin
            pkt_ok_d = 1'b1;
            case (cmd_q)
              CmdHue: sh_hue_d = stage_q;
              CmdSv: begin
                sh_sat_d = stage_q[7:0];
                sh_val_d = stage_q[15:8];
              end
              CmdSig: begin
                sh_sig_d  = stage_q[3:0];
                sh_mode_d = stage_q[4];
              end
              default: commit_acc = 1'b1;
            endcase
          end else begin
            pkt_err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Commit uses the newest shadow, including a write landing on this same edge.
    if (sof && pending_q) begin
      act_hue_d   = sh_hue_d;
      act_sat_d   = sh_sat_d;
      act_val_d   = sh_val_d;
      act_sig_d   = sh_sig_d;
      act_mode_d  = sh_mode_d;
      pending_d   = 1'b0;
      committed_d = 1'b1;
    end
    // A COMMIT accepted alongside sof only arms the next frame.
    if (commit_acc) pending_d = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      cmd_q       <= '0;
      csum_q      <= '0;
      stage_q     <= '0;
      timer_q     <= '0;
      sh_hue_q    <= '0;
      sh_sat_q    <= DEFAULT_SAT;
      sh_val_q    <= DEFAULT_VAL;
      sh_sig_q    <= '0;
      sh_mode_q   <= 1'b0;
      act_hue_q   <= '0;
      act_sat_q   <= DEFAULT_SAT;
      act_val_q   <= DEFAULT_VAL;
      act_sig_q   <= '0;
      act_mode_q  <= 1'b0;
      pending_q   <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      committed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      cmd_q       <= cmd_d;
      csum_q      <= csum_d;
      stage_q     <= stage_d;
      timer_q     <= timer_d;
      sh_hue_q    <= sh_hue_d;
      sh_sat_q    <= sh_sat_d;
      sh_val_q    <= sh_val_d;
      sh_sig_q    <= sh_sig_d;
      sh_mode_q   <= sh_mode_d;
      act_hue_q   <= act_hue_d;
      act_sat_q   <= act_sat_d;
      act_val_q   <= act_val_d;
      act_sig_q   <= act_sig_d;
      act_mode_q  <= act_mode_d;
      pending_q   <= pending_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
      committed_q <= committed_d;
    end
  end

  assign threshue          = act_hue_q;
  assign threshsat         = act_sat_q;
  assign threshval         = act_val_q;
  assign thresholdsig      = act_sig_q;
  assign mode_1_new_signal = act_mode_q;
  assign commit_pending    = pending_q;
  assign pkt_ok            = pkt_ok_q;
  assign pkt_err           = pkt_err_q;
  assign committed         = committed_q;

endmodule

// File: tb/tb_thresh_cfg_loader.sv
// Scoreboard bench for thresh_cfg_loader: stimulus pushes expected pulses/commits,
// a negedge monitor pops and compares whenever the DUT raises a pulse.
module tb_thresh_cfg_loader;

  localparam int unsigned Timeout = 64;
  localparam int KindOk = 0, KindErr = 1, KindCommit = 2;

  typedef struct {
    int           kind;
    logic [143:0] hue;
    logic [7:0]   sat;
    logic [7:0]   val;
    logic [3:0]   sig;
    logic         mode;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         sof = 1'b0;
  logic [143:0] threshue;
  logic [7:0]   threshsat, threshval;
  logic [3:0]   thresholdsig;
  logic         mode_1_new_signal, commit_pending, pkt_ok, pkt_err, committed;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  // Shadow model kept by the bench
  logic [143:0] m_hue;
  logic [7:0]   m_sat, m_val;
  logic [3:0]   m_sig;
  logic         m_mode, m_pend;

  thresh_cfg_loader #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .sof(sof),
    .threshue(threshue), .threshsat(threshsat), .threshval(threshval),
    .thresholdsig(thresholdsig), .mode_1_new_signal(mode_1_new_signal),
    .commit_pending(commit_pending), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
    .committed(committed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_event(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = sb.pop_front();
      check("event_kind", 144'(kind), 144'(e.kind));
      if (e.kind == KindCommit && kind == KindCommit) begin
        check("commit_hue", threshue, e.hue);
        check("commit_sat", 144'(threshsat), 144'(e.sat));
        check("commit_val", 144'(threshval), 144'(e.val));
        check("commit_sig", 144'(thresholdsig), 144'(e.sig));
        check("commit_mode", 144'(mode_1_new_signal), 144'(e.mode));
      end
    end
  endtask

  // Monitor: compare each DUT pulse against the scoreboard head
  always @(negedge clk) begin
    if (!reset) begin
      if (pkt_err)   expect_event(KindErr);
      if (pkt_ok)    expect_event(KindOk);
      if (committed) expect_event(KindCommit);
    end
  end

  function automatic exp_t mk(input int kind);
    exp_t e;
    e.kind = kind; e.hue = m_hue; e.sat = m_sat; e.val = m_val;
    e.sig = m_sig; e.mode = m_mode;
    return e;
  endfunction

  task automatic model_reset();
    m_hue = '0; m_sat = 8'd100; m_val = 8'd100; m_sig = '0; m_mode = 1'b0; m_pend = 1'b0;
  endtask

  task automatic model_sof();
    if (m_pend) begin
      sb.push_back(mk(KindCommit));
      m_pend = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s = 1'b0);
    in_valid = 1'b1; in_data = b; sof = s;
    @(posedge clk); #1;
    in_valid = 1'b0; sof = 1'b0;
  endtask

  // Send a full packet; ok says whether the hand-chosen checksum is correct
  task automatic send_pkt(input logic [7:0] cmd, input logic [143:0] pl, input int n,
                          input logic [7:0] cs, input bit ok, input bit sof_last = 1'b0);
    if (sof_last) model_sof();
    if (ok) begin
      sb.push_back(mk(KindOk));
      case (cmd)
        8'h01: m_hue = pl;
        8'h02: begin m_sat = pl[7:0]; m_val = pl[15:8]; end
        8'h03: begin m_sig = pl[3:0]; m_mode = pl[4]; end
        default: m_pend = 1'b1;
      endcase
    end else begin
      sb.push_back(mk(KindErr));
    end
    send_byte(8'hA5);
    send_byte(cmd);
    for (int k = 0; k < n; k++) send_byte(pl[8*k +: 8]);
    send_byte(cs, sof_last);
  endtask

  task automatic pulse_sof();
    model_sof();
    sof = 1'b1;
    @(posedge clk); #1;
    sof = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic commit_now();
    send_pkt(8'h10, '0, 0, 8'h10, 1'b1);
    drain(20);
    pulse_sof();
    drain(20);
  endtask

  logic [143:0] hue_pl;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_sat", 144'(threshsat), 144'(8'd100));
    check("rst_val", 144'(threshval), 144'(8'd100));
    check("rst_hue", threshue, 144'd0);
    check("rst_sig", 144'(thresholdsig), 144'd0);
    check("rst_mode", 144'(mode_1_new_signal), 144'd0);
    check("rst_pending", 144'(commit_pending), 144'd0);
    check("rst_pulses", 144'({pkt_ok, pkt_err, committed}), 144'd0);
    pulse_sof();
    repeat (3) @(posedge clk);
    #1 check("sof_idle_sat", 144'(threshsat), 144'(8'd100));

    // SV then COMMIT then sof
    send_pkt(8'h02, 144'h8040, 2, 8'hC2, 1'b1);
    send_pkt(8'h10, '0, 0, 8'h10, 1'b1);
    drain(20);
    check("pending_set", 144'(commit_pending), 144'd1);
    check("pre_sof_sat", 144'(threshsat), 144'(8'd100));
    pulse_sof();
    drain(20);
    check("pending_clr", 144'(commit_pending), 144'd0);

    // HUE bytes 0x01..0x12, checksum 0x01 ^ (1^..^18) = 0x12
    for (int k = 0; k < 18; k++) hue_pl[8*k +: 8] = 8'(k + 1);
    send_pkt(8'h01, hue_pl, 18, 8'h12, 1'b1);
    commit_now();
    check("hue_lo", 144'(threshue[7:0]), 144'(8'h01));
    check("hue_hi", 144'(threshue[143:136]), 144'(8'h12));

    // Good SIG (sig=5, mode=1), then bad SIG must not disturb it
    send_pkt(8'h03, 144'h15, 1, 8'h16, 1'b1);
    commit_now();
    send_pkt(8'h03, 144'h1A, 1, 8'h00, 1'b0);
    commit_now();
    check("sig_kept", 144'(thresholdsig), 144'(4'h5));
    check("mode_kept", 144'(mode_1_new_signal), 144'd1);

    // Noise before sync, SIG with upper bits set, 0xA5 as payload, unknown cmd
    send_byte(8'h00);
    send_byte(8'hFF);
    send_pkt(8'h03, 144'hE7, 1, 8'hE4, 1'b1);
    send_pkt(8'h02, 144'hA5A5, 2, 8'h02, 1'b1);
    sb.push_back(mk(KindErr));
    send_byte(8'hA5);
    send_byte(8'h55);
    drain(20);
    commit_now();

    // Timeout mid-packet, then a valid packet is accepted
    sb.push_back(mk(KindErr));
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h40);
    drain(Timeout + 20);
    send_pkt(8'h02, 144'h2211, 2, 8'h31, 1'b1);
    drain(20);

    // COMMIT checksum on the sof cycle: applies only on the following sof
    send_byte(8'h00);
    send_pkt(8'h10, '0, 0, 8'h10, 1'b1, 1'b1);
    drain(20);
    check("coinc_sat_hold", 144'(threshsat), 144'(8'hA5));
    check("coinc_pending", 144'(commit_pending), 144'd1);
    pulse_sof();
    drain(20);
    check("coinc_sat_new", 144'(threshsat), 144'(8'h11));

    // Double COMMIT while pending, shadow write after first COMMIT included
    send_pkt(8'h10, '0, 0, 8'h10, 1'b1);
    send_pkt(8'h02, 144'h4433, 2, 8'h75, 1'b1);
    send_pkt(8'h10, '0, 0, 8'h10, 1'b1);
    drain(20);
    pulse_sof();
    repeat (3) @(posedge clk);
    #1 drain(20);

    // Reset mid-packet: no pulse, shadow and active back to defaults
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h12);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rr_sat", 144'(threshsat), 144'(8'd100));
    check("rr_hue", threshue, 144'd0);
    repeat (4) @(posedge clk);
    #1;
    commit_now();

    repeat (5) @(posedge clk);
    #1 drain(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
